// File: rtl/core_run_ctrl_pkg.sv
// Shared definitions for the core run-control block.
//   run_state_t     : FSM state encoding (IDLE, HOLD, RUN, DONE)
//   TOHOST_ADDR_DEF : default store address that ends a program
//   PASS_CODE       : tohost write value that reports success
package riscv_run_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } run_state_t;

   localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_0FFC;
   localparam int          PASS_CODE       = 1;

endpackage

// File: rtl/core_run_ctrl_if.sv
// Bus between the single-cycle core and its run controller.
//   pc        : core program counter (core -> ctrl)
//   mem_we    : data-memory write enable (core -> ctrl)
//   mem_addr  : data-memory address (core -> ctrl)
//   mem_wdata : data-memory write data (core -> ctrl)
//   core_rst  : active-low reset to the core (ctrl -> core)
// master = core side, slave = run controller side.
interface core_run_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] pc;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              core_rst;

   modport master (output pc, mem_we, mem_addr, mem_wdata, input core_rst);
   modport slave  (input pc, mem_we, mem_addr, mem_wdata, output core_rst);
endinterface

// File: rtl/core_run_ctrl_loop_detect.sv
// PC self-loop detector for the run controller.
//   clk, rst : clock and asynchronous active-low reset
//   active   : high while the core is running; low clears the history
//   pc       : current program counter
//   hang_hit : this cycle completes LOOP_LIMIT consecutive cycles on one PC
module run_loop_detect #(
   parameter int ADDR_W     = 32,
   parameter int LOOP_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              active,
   input  logic [ADDR_W-1:0] pc,
   output logic              hang_hit
);
   localparam int LW = $clog2(LOOP_LIMIT) + 1;

   logic [ADDR_W-1:0] last_pc;
   logic [LW-1:0]     loop_cnt;
   logic              same_pc;

   assign same_pc  = (pc == last_pc);
   // The counter is about to reach LOOP_LIMIT-1 on this repeat.
   assign hang_hit = active && same_pc && (loop_cnt == LW'(LOOP_LIMIT - 2));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_pc  <= '0;
         loop_cnt <= '0;
      end else if (!active) begin
         // Every run starts comparing against a cleared last_pc.
         last_pc  <= '0;
         loop_cnt <= '0;
      end else begin
         last_pc <= pc;
         if (!same_pc)
            loop_cnt <= '0;
         else if (loop_cnt != LW'(LOOP_LIMIT - 1))
            loop_cnt <= loop_cnt + LW'(1);
      end
   end
endmodule

// File: rtl/core_run_ctrl.sv
// Run-control and completion monitor for the single-cycle RISC-V core.
// Holds the core in reset for RST_HOLD_CYCLES after start, counts RUN cycles
// and stops the run on a tohost store, a PC self-loop or the cycle budget.
//   clk, rst    : clock and asynchronous active-low reset
//   start       : one-cycle (re)run request, honoured in IDLE and DONE
//   bus         : core bus (pc, mem_we, mem_addr, mem_wdata in; core_rst out)
//   running     : high while in RUN
//   done        : sticky end-of-run flag
//   pass        : tohost store of PASS_CODE ended the run
//   timeout     : cycle budget ended the run
//   hang        : PC self-loop ended the run
//   result      : tohost data of the terminating store, else 0
//   cycle_count : RUN cycles elapsed, frozen in DONE
module core_run_ctrl
   import riscv_run_pkg::*;
#(
   parameter int              ADDR_W          = 32,
   parameter int              DATA_W          = 32,
   parameter int              CNT_W           = 32,
   parameter int              RST_HOLD_CYCLES = 2,
   parameter int              MAX_CYCLES      = 1000,
   parameter int              LOOP_LIMIT      = 4,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR   = ADDR_W'(TOHOST_ADDR_DEF)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   core_run_ctrl_if.slave      bus,
   output logic                running,
   output logic                done,
   output logic                pass,
   output logic                timeout,
   output logic                hang,
   output logic [DATA_W-1:0]   result,
   output logic [CNT_W-1:0]    cycle_count
);
   localparam int               HOLD_W     = $clog2(RST_HOLD_CYCLES) + 1;
   localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

   run_state_t        state;
   logic [HOLD_W-1:0] hold_cnt;
   logic              core_rst_q;
   logic              run_active;
   logic              tohost_hit;
   logic              hang_hit;
   logic              budget_hit;

   // Increment that sticks at all-ones so the count can never wrap.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   assign bus.core_rst = core_rst_q;
   assign run_active   = (state == RUN);
   assign tohost_hit   = bus.mem_we && (bus.mem_addr == TOHOST_ADDR);
   assign budget_hit   = (cycle_count == LAST_CYCLE);

   run_loop_detect #(
      .ADDR_W     (ADDR_W),
      .LOOP_LIMIT (LOOP_LIMIT)
   ) u_loop_detect (
      .clk      (clk),
      .rst      (rst),
      .active   (run_active),
      .pc       (bus.pc),
      .hang_hit (hang_hit)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         hold_cnt    <= '0;
         core_rst_q  <= 1'b0;
         running     <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         timeout     <= 1'b0;
         hang        <= 1'b0;
         result      <= '0;
         cycle_count <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state       <= HOLD;
                  hold_cnt    <= HOLD_W'(RST_HOLD_CYCLES - 1);
                  done        <= 1'b0;
                  pass        <= 1'b0;
                  timeout     <= 1'b0;
                  hang        <= 1'b0;
                  result      <= '0;
                  cycle_count <= '0;
               end
            end
            HOLD: begin
               // Counter runs RST_HOLD_CYCLES-1 .. 0, one HOLD cycle each.
               if (hold_cnt == '0) begin
                  state      <= RUN;
                  core_rst_q <= 1'b1;
                  running    <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt - HOLD_W'(1);
               end
            end
            RUN: begin
               cycle_count <= sat_inc(cycle_count);
               // Priority: tohost store, then PC loop, then budget.
               if (tohost_hit) begin
                  result <= bus.mem_wdata;
                  pass   <= (bus.mem_wdata == DATA_W'(PASS_CODE));
               end else if (hang_hit) begin
                  hang <= 1'b1;
               end else if (budget_hit) begin
                  timeout <= 1'b1;
               end
               if (tohost_hit || hang_hit || budget_hit) begin
                  state      <= DONE;
                  done       <= 1'b1;
                  core_rst_q <= 1'b0;
                  running    <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: reset, start sequencing, pass, fail with
// priority over hang, hang, timeout, start ignored in RUN, abort and rerun.
module tb_core_run_ctrl;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              running;
   logic              done;
   logic              pass;
   logic              timeout;
   logic              hang;
   logic [DATA_W-1:0] result;
   logic [CNT_W-1:0]  cycle_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   core_run_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   core_run_ctrl #(
      .ADDR_W          (ADDR_W),
      .DATA_W          (DATA_W),
      .CNT_W           (CNT_W),
      .RST_HOLD_CYCLES (2),
      .MAX_CYCLES      (50),
      .LOOP_LIMIT      (4),
      .TOHOST_ADDR     (32'h0000_0FFC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .bus         (bus),
      .running     (running),
      .done        (done),
      .pass        (pass),
      .timeout     (timeout),
      .hang        (hang),
      .result      (result),
      .cycle_count (cycle_count)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic cr, input logic run,
                           input logic dn, input logic ps, input logic to,
                           input logic hg, input logic [31:0] res, input logic [31:0] cnt);
      chk({tag, ".core_rst"}, 64'(bus.core_rst), 64'(cr));
      chk({tag, ".running"},  64'(running),      64'(run));
      chk({tag, ".done"},     64'(done),         64'(dn));
      chk({tag, ".pass"},     64'(pass),         64'(ps));
      chk({tag, ".timeout"},  64'(timeout),      64'(to));
      chk({tag, ".hang"},     64'(hang),         64'(hg));
      chk({tag, ".result"},   64'(result),       64'(res));
      chk({tag, ".count"},    64'(cycle_count),  64'(cnt));
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] p, input logic we,
                        input logic [31:0] a, input logic [31:0] d);
      bus.pc        = p;
      bus.mem_we    = we;
      bus.mem_addr  = a;
      bus.mem_wdata = d;
   endtask

   // Start pulse plus the two HOLD cycles; returns in the first RUN cycle.
   task automatic start_run;
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      tick;
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      drive(32'h0, 1'b0, 32'h0, 32'h0);
      #1 rst = 1'b0;
      #2;
      chk_outs("reset_async", 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) tick;
      chk_outs("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      tick;
      tick;
      chk("idle_core_rst", 64'(bus.core_rst), 64'd0);

      // Start: two HOLD cycles with core_rst low, then RUN.
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("hold1_core_rst", 64'(bus.core_rst), 64'd0);
      chk("hold1_running",  64'(running),      64'd0);
      tick;
      chk("hold2_core_rst", 64'(bus.core_rst), 64'd0);
      tick;
      chk("run_core_rst", 64'(bus.core_rst), 64'd1);
      chk("run_running",  64'(running),      64'd1);
      chk("run_cnt0",     64'(cycle_count),  64'd0);

      // Pass: store to a neighbouring address must not end the run.
      for (int k = 1; k <= 19; k++) begin
         if (k == 5) drive(32'h1000 + 4 * k, 1'b1, 32'h0000_0FF8, 32'h1);
         else        drive(32'h1000 + 4 * k, 1'b0, 32'h0, 32'h0);
         tick;
         if (k == 1) chk("cnt_first", 64'(cycle_count), 64'd1);
      end
      chk("pre_pass_done", 64'(done),        64'd0);
      chk("pre_pass_cnt",  64'(cycle_count), 64'd19);
      drive(32'h1050, 1'b1, 32'h0000_0FFC, 32'h1);
      tick;
      chk_outs("pass", 0, 0, 1, 1, 0, 0, 32'h1, 20);
      drive(32'h1054, 1'b0, 32'h0, 32'h0);
      tick;
      tick;
      chk_outs("pass_sticky", 0, 0, 1, 1, 0, 0, 32'h1, 20);

      // Rerun from DONE, then fail store that also completes a PC loop.
      start = 1'b1;
      tick;
      start = 1'b0;
      chk_outs("rerun_hold1", 0, 0, 0, 0, 0, 0, 0, 0);
      tick;
      chk("rerun_hold2_core_rst", 64'(bus.core_rst), 64'd0);
      tick;
      chk("rerun_run_core_rst", 64'(bus.core_rst), 64'd1);
      repeat (3) begin
         drive(32'h100, 1'b0, 32'h0, 32'h0);
         tick;
      end
      chk("fail_pre_done", 64'(done), 64'd0);
      drive(32'h100, 1'b1, 32'h0000_0FFC, 32'h2A);
      tick;
      chk_outs("fail", 0, 0, 1, 0, 0, 0, 32'h2A, 4);
      drive(32'h0, 1'b0, 32'h0, 32'h0);

      // Hang: PC held at 0x40 from RUN entry.
      start_run;
      repeat (3) begin
         drive(32'h40, 1'b0, 32'h0, 32'h0);
         tick;
      end
      chk("hang_pre_done", 64'(done), 64'd0);
      tick;
      chk_outs("hang", 0, 0, 1, 0, 0, 1, 0, 4);

      // Timeout: PC walks by 4; a start pulse mid-run is ignored.
      start_run;
      for (int k = 0; k < 49; k++) begin
         drive(32'h200 + 4 * k, 1'b0, 32'h0, 32'h0);
         if (k == 10) start = 1'b1;
         tick;
         start = 1'b0;
         if (k == 10) begin
            chk("start_in_run_running",  64'(running),      64'd1);
            chk("start_in_run_core_rst", 64'(bus.core_rst), 64'd1);
            chk("start_in_run_cnt",      64'(cycle_count),  64'd11);
         end
      end
      chk("to_pre_done", 64'(done),        64'd0);
      chk("to_pre_cnt",  64'(cycle_count), 64'd49);
      drive(32'h200 + 4 * 49, 1'b0, 32'h0, 32'h0);
      tick;
      chk_outs("timeout", 0, 0, 1, 0, 1, 0, 0, 50);

      // Abort: rst mid-RUN clears everything without a clock edge.
      start_run;
      for (int k = 0; k < 5; k++) begin
         drive(32'h300 + 4 * k, 1'b0, 32'h0, 32'h0);
         tick;
      end
      chk("abort_pre_running", 64'(running), 64'd1);
      #2 rst = 1'b0;
      #1;
      chk_outs("abort", 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) tick;
      rst = 1'b1;
      tick;
      tick;
      chk("abort_idle_core_rst", 64'(bus.core_rst), 64'd0);
      chk("abort_idle_running",  64'(running),      64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Run-control and completion monitor for the single-cycle RISC-V core.
- Sequences the core's reset on a start request and counts executed cycles.
- Detects end-of-program: a store to a "tohost" address, a PC self-loop (`j .`), or a cycle budget expiring.
- Reports pass/fail/timeout so simulation and FPGA runs terminate deterministically instead of relying on fixed delays.

Parameters:
ADDR_W, 32, width of PC and data-memory address
DATA_W, 32, width of store data
CNT_W, 32, width of cycle counter
RST_HOLD_CYCLES, 2, cycles core_rst is held low after start (min 1)
MAX_CYCLES, 1000, run-cycle budget before timeout (1 to 2^CNT_W-1)
LOOP_LIMIT, 4, consecutive cycles with unchanged PC that count as a halt loop (min 2)
TOHOST_ADDR, 32'h0000_0FFC, store address signalling program end

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse requesting a (re)run
pc  in  ADDR_W  core program counter
mem_we  in  1  core data-memory write enable
mem_addr  in  ADDR_W  core data-memory address
mem_wdata  in  DATA_W  core data-memory write data
core_rst  out  1  active-low reset driven to the core
running  out  1  high while in RUN
done  out  1  high in DONE, sticky until next start or rst
pass  out  1  valid when done: tohost store with wdata==1
timeout  out  1  valid when done: budget exhausted
hang  out  1  valid when done: PC loop detected
result  out  DATA_W  wdata of the terminating tohost store, else 0
cycle_count  out  CNT_W  RUN cycles elapsed; frozen in DONE

Behaviour:
- rst low (async), all of the following hold immediately:
  - state=IDLE, core_rst=0, running=0, done=0, pass=0, timeout=0, hang=0, result=0, cycle_count=0.
  - Internal hold counter, loop counter and last_pc are cleared.
- FSM states: IDLE, HOLD, RUN, DONE. All transitions occur on the rising clk edge.
- IDLE:
  - core_rst=0.
  - start -> HOLD; hold counter loaded with RST_HOLD_CYCLES-1.
- HOLD:
  - core_rst=0; the counter decrements each cycle.
  - When the counter reaches 0, go to RUN.
  - Net effect: core_rst is low for exactly RST_HOLD_CYCLES cycles after the start edge.
  - Entering HOLD clears done, pass, timeout, hang, result and cycle_count.
- RUN:
  - core_rst=1, running=1; cycle_count increments each cycle in RUN.
  - Terminating conditions, evaluated each RUN cycle, highest priority first:
    1. mem_we && mem_addr==TOHOST_ADDR: result<=mem_wdata, pass<=(mem_wdata==1).
    2. Loop counter reaches LOOP_LIMIT-1 while pc==last_pc: hang<=1.
    3. cycle_count==MAX_CYCLES-1: timeout<=1.
  - On any condition -> DONE. Exactly one of pass/hang/timeout/(fail = tohost with wdata!=1) applies, per the priority above.
  - Loop counter: clears when pc!=last_pc, otherwise increments (saturating). last_pc<=pc every RUN cycle. The first RUN cycle compares against the reset-cleared last_pc.
  - cycle_count includes the terminating cycle and never wraps.
- DONE:
  - core_rst=0 (the core is frozen); done=1; flags and count held.
  - start -> HOLD (rerun).
- start in HOLD or RUN is ignored.
- rst asserted mid-run aborts immediately to IDLE; the core is held in reset.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package riscv_run_pkg holds:
  - the state encoding (IDLE=2'd0, HOLD=2'd1, RUN=2'd2, DONE=2'd3);
  - the TOHOST_ADDR default;
  - the PASS_CODE=1 constant.
- One natural sub-module: run_loop_detect. It contains the pc/last_pc compare and the saturating loop counter, with output hang_hit.
- The FSM, hold counter and cycle counter stay in core_run_ctrl.

Test Plan:
- Reset and start: rst low 3 cycles, release, start pulse at cycle 5 -> core_rst low through cycle 6 (RST_HOLD_CYCLES=2), high from cycle 7; running=1; cycle_count=1 after the first RUN edge.
- Pass: in RUN, at the 20th RUN cycle drive mem_we=1, mem_addr=0xFFC, mem_wdata=1 -> next edge done=1, pass=1, result=1, cycle_count=20, core_rst=0.
- Fail plus priority: tohost store with wdata=0x2A while pc has also been static for LOOP_LIMIT cycles -> done=1, pass=0, hang=0, result=0x2A.
- Hang: hold pc=0x40 constant from RUN entry -> done asserts after 4 RUN cycles with hang=1, timeout=0.
- Timeout: MAX_CYCLES=50 and pc incrementing by 4 each cycle with no tohost store -> done at cycle_count=50, timeout=1.
- Abort and rerun: rst low mid-RUN -> all outputs return to reset values asynchronously. Separately, start in DONE -> flags clear and core_rst is low for 2 cycles again. A start pulse during RUN changes nothing.
